// File: rtl/l1_store_queue.sv
// Per-thread L1 store queue: one line-sized entry per thread with merging,
// L2 round-robin issue, load bypass, rollback and sync-store replay.
module l1_store_queue #(
  parameter int THREADS     = 4,
  parameter int LINE_BYTES  = 64,
  parameter int LINE_ADDR_W = 26
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dt_store_en,
  input  logic                          dt_is_sync,
  input  logic [$clog2(THREADS)-1:0]    dt_thread_idx,
  input  logic [LINE_ADDR_W-1:0]        dt_line_addr,
  input  logic [LINE_BYTES-1:0]         dt_store_mask,
  input  logic [LINE_BYTES*8-1:0]       dt_store_data,
  input  logic                          dt_load_en,
  output logic [LINE_BYTES-1:0]         sb_store_bypass_mask,
  output logic [LINE_BYTES*8-1:0]       sb_store_bypass_data,
  output logic                          sb_full_rollback,
  output logic                          sb_store_sync_success,
  output logic [THREADS-1:0]            sq_wake_bitmap,
  output logic                          sq_l2_valid,
  output logic [$clog2(THREADS)-1:0]    sq_l2_thread,
  output logic [LINE_ADDR_W-1:0]        sq_l2_addr,
  output logic [LINE_BYTES-1:0]         sq_l2_mask,
  output logic [LINE_BYTES*8-1:0]       sq_l2_data,
  output logic                          sq_l2_is_sync,
  input  logic                          l2_ready,
  input  logic                          l2_resp_valid,
  input  logic [$clog2(THREADS)-1:0]    l2_resp_thread,
  input  logic                          l2_resp_sync_ok
);
  localparam int TW = $clog2(THREADS);
  localparam int DW = LINE_BYTES * 8;

  typedef enum logic [1:0] {EMPTY, PENDING, SENT, SYNC_DONE} state_e;

  state_e                 state_q [THREADS];
  state_e                 state_d [THREADS];
  logic [LINE_ADDR_W-1:0] addr_q  [THREADS];
  logic [LINE_ADDR_W-1:0] addr_d  [THREADS];
  logic [LINE_BYTES-1:0]  mask_q  [THREADS];
  logic [LINE_BYTES-1:0]  mask_d  [THREADS];
  logic [DW-1:0]          data_q  [THREADS];
  logic [DW-1:0]          data_d  [THREADS];
  logic [THREADS-1:0]     is_sync_q, is_sync_d;
  logic [THREADS-1:0]     sync_res_q, sync_res_d;
  logic [THREADS-1:0]     wait_q, wait_d;
  logic [TW-1:0]          ptr_q, ptr_d;

  logic                   l2_valid_q, l2_valid_d;
  logic [TW-1:0]          l2_thread_q, l2_thread_d;
  logic [LINE_ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [LINE_BYTES-1:0]  l2_mask_q, l2_mask_d;
  logic [DW-1:0]          l2_data_q, l2_data_d;
  logic                   l2_sync_q, l2_sync_d;

  logic [LINE_BYTES-1:0]  byp_mask_q, byp_mask_d;
  logic [DW-1:0]          byp_data_q, byp_data_d;
  logic                   rollback_q, rollback_d;
  logic                   success_q, success_d;
  logic [THREADS-1:0]     wake;
  logic                   found;
  logic [TW-1:0]          sel;

  // Response, then handshake, then store: a store sees the freshest state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    data_d     = data_q;
    is_sync_d  = is_sync_q;
    sync_res_d = sync_res_q;
    wait_d     = wait_q;
    wake       = '0;
    rollback_d = 1'b0;
    success_d  = 1'b0;
    if (l2_resp_valid) begin
      wait_d[l2_resp_thread] = 1'b0;
      wake[l2_resp_thread]   = wait_q[l2_resp_thread];
      if (state_q[l2_resp_thread] == SENT) begin
        if (is_sync_q[l2_resp_thread]) begin
          state_d[l2_resp_thread]    = SYNC_DONE;
          sync_res_d[l2_resp_thread] = l2_resp_sync_ok;
        end else begin
          state_d[l2_resp_thread] = EMPTY;
        end
      end
    end
    if (l2_valid_q && l2_ready && state_d[l2_thread_q] == PENDING)
      state_d[l2_thread_q] = SENT;
    if (dt_store_en) begin
      unique case (1'b1)
        (state_d[dt_thread_idx] == EMPTY): begin
          state_d[dt_thread_idx]   = PENDING;
          addr_d[dt_thread_idx]    = dt_line_addr;
          mask_d[dt_thread_idx]    = dt_store_mask;
          data_d[dt_thread_idx]    = dt_store_data;
          is_sync_d[dt_thread_idx] = dt_is_sync;
          if (dt_is_sync) begin
            rollback_d            = 1'b1;
            wait_d[dt_thread_idx] = 1'b1;
          end
        end
        (!dt_is_sync && state_d[dt_thread_idx] == PENDING
          && !is_sync_d[dt_thread_idx]
          && addr_d[dt_thread_idx] == dt_line_addr): begin
          for (int i = 0; i < LINE_BYTES; i++) begin
            if (dt_store_mask[i]) begin
              mask_d[dt_thread_idx][i]       = 1'b1;
              data_d[dt_thread_idx][8*i+:8] = dt_store_data[8*i+:8];
            end
          end
        end
        (dt_is_sync && state_d[dt_thread_idx] == SYNC_DONE
          && addr_d[dt_thread_idx] == dt_line_addr): begin
          success_d              = sync_res_d[dt_thread_idx];
          state_d[dt_thread_idx] = EMPTY;
        end
        default: begin
          rollback_d            = 1'b1;
          wait_d[dt_thread_idx] = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    byp_mask_d = '0;
    byp_data_d = '0;
    if (dt_load_en && !is_sync_q[dt_thread_idx]
        && (state_q[dt_thread_idx] == PENDING
            || state_q[dt_thread_idx] == SENT)
        && addr_q[dt_thread_idx] == dt_line_addr) begin
      byp_mask_d = mask_q[dt_thread_idx];
      byp_data_d = data_q[dt_thread_idx];
    end
  end

  // A stalled request keeps its thread; its payload tracks merges into it.
  always_comb begin
    found       = 1'b0;
    sel         = ptr_q;
    ptr_d       = ptr_q;
    l2_valid_d  = l2_valid_q;
    l2_thread_d = l2_thread_q;
    if (!l2_valid_q || l2_ready) begin
      for (int i = 0; i < THREADS; i++) begin
        if (!found && state_d[ptr_q + TW'(i)] == PENDING) begin
          found = 1'b1;
          sel   = ptr_q + TW'(i);
        end
      end
      l2_valid_d  = found;
      l2_thread_d = sel;
      if (found) ptr_d = sel + 1'b1;
    end
    l2_addr_d = '0;
    l2_mask_d = '0;
    l2_data_d = '0;
    l2_sync_d = 1'b0;
    if (l2_valid_d) begin
      l2_addr_d = addr_d[l2_thread_d];
      l2_mask_d = mask_d[l2_thread_d];
      l2_data_d = data_d[l2_thread_d];
      l2_sync_d = is_sync_d[l2_thread_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= '{default: EMPTY};
      addr_q      <= '{default: '0};
      mask_q      <= '{default: '0};
      data_q      <= '{default: '0};
      is_sync_q   <= '0;
      sync_res_q  <= '0;
      wait_q      <= '0;
      ptr_q       <= '0;
      l2_valid_q  <= 1'b0;
      l2_thread_q <= '0;
      l2_addr_q   <= '0;
      l2_mask_q   <= '0;
      l2_data_q   <= '0;
      l2_sync_q   <= 1'b0;
      byp_mask_q  <= '0;
      byp_data_q  <= '0;
      rollback_q  <= 1'b0;
      success_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      is_sync_q   <= is_sync_d;
      sync_res_q  <= sync_res_d;
      wait_q      <= wait_d;
      ptr_q       <= ptr_d;
      l2_valid_q  <= l2_valid_d;
      l2_thread_q <= l2_thread_d;
      l2_addr_q   <= l2_addr_d;
      l2_mask_q   <= l2_mask_d;
      l2_data_q   <= l2_data_d;
      l2_sync_q   <= l2_sync_d;
      byp_mask_q  <= byp_mask_d;
      byp_data_q  <= byp_data_d;
      rollback_q  <= rollback_d;
      success_q   <= success_d;
    end
  end

  resp_only_when_sent: assert property (@(posedge clk) disable iff (reset)
    l2_resp_valid |-> state_q[l2_resp_thread] == SENT);

  assign sb_store_bypass_mask  = byp_mask_q;
  assign sb_store_bypass_data  = byp_data_q;
  assign sb_full_rollback      = rollback_q;
  assign sb_store_sync_success = success_q;
  assign sq_wake_bitmap        = wake;
  assign sq_l2_valid           = l2_valid_q;
  assign sq_l2_thread          = l2_thread_q;
  assign sq_l2_addr            = l2_addr_q;
  assign sq_l2_mask            = l2_mask_q;
  assign sq_l2_data            = l2_data_q;
  assign sq_l2_is_sync         = l2_sync_q;
endmodule

// File: tb/tb_l1_store_queue.sv
// Directed bench for l1_store_queue: bypass, merge, rollback/wake,
// sync replay, round-robin stall behaviour and same-cycle free.
module tb_l1_store_queue;
  localparam int T  = 4;
  localparam int LB = 64;
  localparam int AW = 26;
  localparam int DW = LB * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          dt_store_en, dt_is_sync, dt_load_en;
  logic [1:0]    dt_thread_idx;
  logic [AW-1:0] dt_line_addr;
  logic [LB-1:0] dt_store_mask;
  logic [DW-1:0] dt_store_data;
  logic [LB-1:0] sb_store_bypass_mask;
  logic [DW-1:0] sb_store_bypass_data;
  logic          sb_full_rollback, sb_store_sync_success;
  logic [T-1:0]  sq_wake_bitmap;
  logic          sq_l2_valid, sq_l2_is_sync;
  logic [1:0]    sq_l2_thread;
  logic [AW-1:0] sq_l2_addr;
  logic [LB-1:0] sq_l2_mask;
  logic [DW-1:0] sq_l2_data;
  logic          l2_ready, l2_resp_valid, l2_resp_sync_ok;
  logic [1:0]    l2_resp_thread;

  int total = 0;
  int bad   = 0;

  l1_store_queue #(.THREADS(T), .LINE_BYTES(LB), .LINE_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .dt_store_en(dt_store_en), .dt_is_sync(dt_is_sync),
    .dt_thread_idx(dt_thread_idx), .dt_line_addr(dt_line_addr),
    .dt_store_mask(dt_store_mask), .dt_store_data(dt_store_data),
    .dt_load_en(dt_load_en),
    .sb_store_bypass_mask(sb_store_bypass_mask),
    .sb_store_bypass_data(sb_store_bypass_data),
    .sb_full_rollback(sb_full_rollback),
    .sb_store_sync_success(sb_store_sync_success),
    .sq_wake_bitmap(sq_wake_bitmap),
    .sq_l2_valid(sq_l2_valid), .sq_l2_thread(sq_l2_thread),
    .sq_l2_addr(sq_l2_addr), .sq_l2_mask(sq_l2_mask),
    .sq_l2_data(sq_l2_data), .sq_l2_is_sync(sq_l2_is_sync),
    .l2_ready(l2_ready), .l2_resp_valid(l2_resp_valid),
    .l2_resp_thread(l2_resp_thread), .l2_resp_sync_ok(l2_resp_sync_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dt_store_en     = 1'b0;
    dt_is_sync      = 1'b0;
    dt_load_en      = 1'b0;
    dt_thread_idx   = '0;
    dt_line_addr    = '0;
    dt_store_mask   = '0;
    dt_store_data   = '0;
    l2_resp_valid   = 1'b0;
    l2_resp_thread  = '0;
    l2_resp_sync_ok = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int t, input int a, input logic [LB-1:0] m,
                       input logic [DW-1:0] d, input logic s);
    idle();
    dt_store_en   = 1'b1;
    dt_is_sync    = s;
    dt_thread_idx = 2'(t);
    dt_line_addr  = AW'(a);
    dt_store_mask = m;
    dt_store_data = d;
  endtask

  task automatic load(input int t, input int a);
    idle();
    dt_load_en    = 1'b1;
    dt_thread_idx = 2'(t);
    dt_line_addr  = AW'(a);
  endtask

  task automatic resp(input int t, input logic ok);
    l2_resp_valid   = 1'b1;
    l2_resp_thread  = 2'(t);
    l2_resp_sync_ok = ok;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    l2_ready = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_l2_valid", sq_l2_valid, 0);
    chk("rst_wake", sq_wake_bitmap, 0);
    chk("rst_rollback", sb_full_rollback, 0);
    chk("rst_byp_mask", sb_store_bypass_mask, 0);
    chk("rst_sync_ok", sb_store_sync_success, 0);

    // store then load bypass
    store(0, 'h10, 64'h1, 512'hA5, 1'b0);
    tick();
    chk("st_rollback", sb_full_rollback, 0);
    chk("st_req_valid", sq_l2_valid, 1);
    load(0, 'h10);
    tick();
    chk("byp_mask", sb_store_bypass_mask, 1);
    chk("byp_data", sb_store_bypass_data, 'hA5);
    chk("byp_rollback", sb_full_rollback, 0);
    load(0, 'h11);
    tick();
    chk("byp_miss_mask", sb_store_bypass_mask, 0);
    chk("byp_miss_data", sb_store_bypass_data, 0);

    // reset with a request outstanding drops it
    do_reset();
    chk("mid_rst_valid", sq_l2_valid, 0);

    // merge before grant
    store(1, 'h40, 64'h3, 512'h2211, 1'b0);
    tick();
    store(1, 'h40, 64'h6, 512'h443300, 1'b0);
    tick();
    idle();
    chk("mrg_rollback", sb_full_rollback, 0);
    chk("mrg_valid", sq_l2_valid, 1);
    chk("mrg_thread", sq_l2_thread, 1);
    chk("mrg_addr", sq_l2_addr, 'h40);
    chk("mrg_mask", sq_l2_mask, 7);
    chk("mrg_data", sq_l2_data, 'h443311);
    chk("mrg_sync", sq_l2_is_sync, 0);
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
    chk("mrg_after_grant", sq_l2_valid, 0);

    // rollback while SENT, wake on response
    do_reset();
    store(0, 'h10, 64'h1, 512'h5A, 1'b0);
    tick();
    idle();
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
    store(0, 'h20, 64'h1, 512'h77, 1'b0);
    tick();
    chk("rej_rollback", sb_full_rollback, 1);
    load(0, 'h10);
    tick();
    chk("sent_byp_mask", sb_store_bypass_mask, 1);
    chk("sent_byp_data", sb_store_bypass_data, 'h5A);
    chk("sent_rollback_clr", sb_full_rollback, 0);
    idle();
    resp(0, 1'b0);
    #1;
    chk("wake_pulse", sq_wake_bitmap, 4'b0001);
    tick();
    idle();
    #1;
    chk("wake_clear", sq_wake_bitmap, 0);
    load(0, 'h10);
    tick();
    chk("freed_byp_mask", sb_store_bypass_mask, 0);

    // sync store, response, replay
    do_reset();
    store(2, 'h30, 64'hF, 512'hDEADBEEF, 1'b1);
    tick();
    chk("sync_rollback", sb_full_rollback, 1);
    chk("sync_valid", sq_l2_valid, 1);
    chk("sync_thread", sq_l2_thread, 2);
    chk("sync_addr", sq_l2_addr, 'h30);
    chk("sync_flag", sq_l2_is_sync, 1);
    load(2, 'h30);
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
    chk("sync_no_byp", sb_store_bypass_mask, 0);
    chk("sync_load_no_rb", sb_full_rollback, 0);
    idle();
    resp(2, 1'b1);
    #1;
    chk("sync_wake", sq_wake_bitmap, 4'b0100);
    tick();
    store(2, 'h30, 64'hF, 512'hDEADBEEF, 1'b1);
    tick();
    chk("replay_success", sb_store_sync_success, 1);
    chk("replay_rollback", sb_full_rollback, 0);
    store(2, 'h30, 64'hF, 512'hDEADBEEF, 1'b1);
    tick();
    chk("realloc_rollback", sb_full_rollback, 1);
    chk("realloc_success", sb_store_sync_success, 0);

    // all four pending, stall then round robin
    do_reset();
    for (int i = 0; i < 4; i++) begin
      store(i, 'h100 + i, 64'(1) << i, 512'(8'h10 + i), 1'b0);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", sq_l2_valid, 1);
      chk("stall_thread", sq_l2_thread, 0);
      chk("stall_addr", sq_l2_addr, 'h100);
      tick();
    end
    l2_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_valid", sq_l2_valid, 1);
      chk("rr_thread", sq_l2_thread, 512'(i));
      chk("rr_addr", sq_l2_addr, 512'('h100 + i));
      chk("rr_mask", sq_l2_mask, 512'(64'(1) << i));
      tick();
    end
    l2_ready = 1'b0;
    chk("rr_done", sq_l2_valid, 0);

    // response and store for the same thread in one cycle
    store(3, 'h200, 64'h1, 512'h99, 1'b0);
    resp(3, 1'b0);
    #1;
    chk("same_cyc_no_wake", sq_wake_bitmap, 0);
    tick();
    idle();
    chk("same_cyc_rollback", sb_full_rollback, 0);
    chk("same_cyc_valid", sq_l2_valid, 1);
    chk("same_cyc_thread", sq_l2_thread, 3);
    chk("same_cyc_addr", sq_l2_addr, 'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_store_queue.md
# l1_store_queue

Per-thread store queue between the dcache tag stage and the writeback stage. It holds one pending cache-line store per thread and merges repeat stores to the same line. It sends stores to L2 over a valid/ready handshake and frees entries on the L2 response. Each cycle it gives the writeback stage load-bypass data, a rollback request when a store can't be accepted, and the result of synchronized stores.

## Interface
- THREADS, default 4: hardware threads per core; power of two, at least 2.
- LINE_BYTES, default 64: cache line size in bytes.
- LINE_ADDR_W, default 26: width of a line address (byte address >> log2(LINE_BYTES)).
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- dt_store_en  in  1  store request from the tag stage this cycle
- dt_is_sync  in  1  store is synchronized (store-conditional)
- dt_thread_idx  in  log2(THREADS)  thread of the store or bypass lookup
- dt_line_addr  in  LINE_ADDR_W  line address of the store or load
- dt_store_mask  in  LINE_BYTES  byte enables
- dt_store_data  in  LINE_BYTES*8  store data, byte i at bits [8i+:8]
- dt_load_en  in  1  load lookup this cycle; never asserted together with dt_store_en
- sb_store_bypass_mask  out  LINE_BYTES  bytes to override in load data (registered)
- sb_store_bypass_data  out  LINE_BYTES*8  override data (registered)
- sb_full_rollback  out  1  store was not accepted; roll back the thread (registered)
- sb_store_sync_success  out  1  result of a replayed sync store (registered)
- sq_wake_bitmap  out  THREADS  one-cycle wake pulse per thread
- sq_l2_valid  out  1  L2 store request valid
- sq_l2_thread  out  log2(THREADS)  entry/thread of the request
- sq_l2_addr  out  LINE_ADDR_W  line address
- sq_l2_mask  out  LINE_BYTES  byte enables
- sq_l2_data  out  LINE_BYTES*8  data
- sq_l2_is_sync  out  1  synchronized store
- l2_ready  in  1  L2 accepts the request this cycle
- l2_resp_valid  in  1  store acknowledgement
- l2_resp_thread  in  log2(THREADS)  entry being acknowledged
- l2_resp_sync_ok  in  1  sync store succeeded (valid only for sync entries)

## Operation
- Each thread has one entry: state (EMPTY, PENDING, SENT, SYNC_DONE), line address, mask, data, is_sync, sync_result, wait flag.
- Transitions:
  - EMPTY→PENDING on allocate.
  - PENDING→SENT on the L2 handshake (sq_l2_valid && l2_ready).
  - On response: SENT→EMPTY if !is_sync; SENT→SYNC_DONE if is_sync, latching sync_result = l2_resp_sync_ok.
  - SYNC_DONE→EMPTY on the sync replay.
- Response handling happens before store handling in the same cycle. A store sees the entry state after any same-cycle response.
- A normal store, by entry state:
  - EMPTY: allocate (mask and data copied); no rollback.
  - PENDING, same address, !is_sync: merge. For each set byte of dt_store_mask, update the mask bit and replace the data byte. No rollback.
  - Anything else: reject. sb_full_rollback=1 and the wait flag is set.
- A sync store, by entry state:
  - EMPTY: allocate with is_sync=1. sb_full_rollback=1 and the wait flag is set. The thread sleeps until the response.
  - SYNC_DONE, same address: no rollback; sb_store_sync_success=sync_result; the entry is freed.
  - Anything else: reject, as for a normal store.
- sync_result is never overwritten by a later request.
- Any response clears the wait flag of that entry. If the flag was set, the response pulses sq_wake_bitmap[thread] in the same cycle.
- Bypass: for a dt_load_en lookup, the entry for dt_thread_idx is used when it is PENDING or SENT with !is_sync and the address matches. If used, the outputs give its mask and data; otherwise mask=0 and data=0. The lookup uses state from before this cycle's update.
- L2 arbiter: round-robin over PENDING entries, with the pointer starting one past the last granted thread. The request holds stable while sq_l2_valid && !l2_ready.

## Timing
- Reset values: all entries EMPTY, wait flags 0, arbiter pointer 0. All outputs 0, including sq_l2_valid and sq_wake_bitmap.
- Inputs presented in cycle N give sb_* outputs in cycle N+1, aligned with the dcache data stage. These outputs are 0 in any cycle not following a lookup or store.
- The earliest L2 request for an allocated entry is cycle N+1. sq_l2_* are registered.
- A response in cycle M frees the entry for a store in the same cycle M. The wake pulse is in cycle M.
- A response for an entry that is not SENT is illegal; flag it with an assertion.
- Reset mid-transaction drops all entries with no L2 side effects.

## Test plan
- Thread 0 stores mask=0x1, addr 0x10; thread 0 then loads addr 0x10 → next cycle bypass mask=0x1, data byte 0 equals the stored byte, rollback=0.
- Two stores to the same line (masks 0x3 and 0x6) before grant → one L2 request with mask=0x7; byte 1 taken from the second store.
- A store to addr 0x20 while an entry to 0x10 is SENT → sb_full_rollback=1. The response for the entry → sq_wake_bitmap=0001 in that cycle.
- Sync store to 0x30 → rollback=1, then L2 request with is_sync=1. Response sync_ok=1 → wake pulse. Replay → sb_store_sync_success=1, rollback=0, entry EMPTY.
- All 4 threads PENDING, l2_ready held low for 3 cycles then high → request is stable while stalled; grants go to threads 0,1,2,3 in order.
- Response and a new store for the same thread in one cycle → store accepted, no rollback.
